// File: rtl/sseg_pkg.sv
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared types and constants for the seven-segment scan driver:
//                conversion FSM states, digit count, BCD ceiling, anode
//                one-hot-low patterns and the double-dabble adjust step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    // Active-low anode patterns, bit 0 = least significant digit
    localparam logic [3:0] c_an_dig0 = 4'b1110;
    localparam logic [3:0] c_an_dig1 = 4'b1101;
    localparam logic [3:0] c_an_dig2 = 4'b1011;
    localparam logic [3:0] c_an_dig3 = 4'b0111;

    // One double-dabble correction: every BCD nibble >= 5 gets +3 so the
    // following left shift carries correctly into the next decade.
    function automatic logic [4*NUM_DIGITS-1:0] dabble_adjust(
        input logic [4*NUM_DIGITS-1:0] s
    );
        logic [4*NUM_DIGITS-1:0] r;
        r = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_bin2bcd.sv
// ============================================================================
//  Module      : sseg_bin2bcd
//  Description : Sequential binary-to-BCD converter (shift-add-3, one bit per
//                clock). Input is saturated to 9999 on load. done pulses for
//                the single cycle in which the finished BCD word is valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_bin2bcd
    import sseg_pkg::*;
#(
    parameter int VAL_W = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VAL_W-1:0]        value,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [VAL_W-1:0]        r_shift;
    logic [4*NUM_DIGITS-1:0] r_scratch;
    logic [CNT_W-1:0]        r_cnt;
    logic [VAL_W-1:0]        w_value_sat;

    // Clamp the request to the largest value four digits can show
    assign w_value_sat = (32'(value) > 32'(BCD_MAX)) ? VAL_W'(BCD_MAX) : value;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore outputs; loads outside IDLE are simply dropped
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Conversion datapath: capture on load, adjust-then-shift while converting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift   <= w_value_sat;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(VAL_W);
                    end
                end
                CONV: begin
                    {r_scratch, r_shift} <= {dabble_adjust(r_scratch), r_shift} << 1;
                    r_cnt                <= r_cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd = r_scratch;

endmodule

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
// ============================================================================
//  Module      : sseg_scan_driver
//  Description : Converts a binary value to four BCD digits and time-multiplexes
//                them onto one shared seven-segment decoder with active-low
//                anode selects for a common-anode display.
//                Optional macro SSEG_LZB_EN enables leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int VAL_W       = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit,
    output logic             blank,
    output logic [3:0]       an
);

    localparam int             REF_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] c_ref_last = REF_W'(REFRESH_DIV - 1);

    logic                    w_conv_done;
    logic [4*NUM_DIGITS-1:0] w_scratch;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] w_disp_next;
    logic [REF_W-1:0]        r_refresh;
    logic [1:0]              r_index;
    logic [3:0]              w_an_next;
    logic                    w_blank_next;
    logic [3:0]              r_an;
    logic [3:0]              r_digit;
    logic                    r_blank;

    sseg_bin2bcd #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (w_conv_done),
        .bcd   (w_scratch)
    );

    assign done = w_conv_done;

    // The display word as it will read after this edge; feeding the output
    // registers from it makes new digits appear in the cycle after commit.
    assign w_disp_next = w_conv_done ? w_scratch : r_disp;

    // Display registers: only ever replaced by a complete conversion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp <= '0;
        end else begin
            r_disp <= w_disp_next;
        end
    end

    // Free-running refresh counter and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_index   <= 2'd0;
        end else if (r_refresh == c_ref_last) begin
            r_refresh <= '0;
            r_index   <= r_index + 2'd1;
        end else begin
            r_refresh <= r_refresh + REF_W'(1);
        end
    end

    // Anode pattern for the current index
    always_comb begin
        w_an_next = c_an_dig0;
        case (r_index)
            2'd0: w_an_next = c_an_dig0;
            2'd1: w_an_next = c_an_dig1;
            2'd2: w_an_next = c_an_dig2;
            2'd3: w_an_next = c_an_dig3;
            default: w_an_next = c_an_dig0;
        endcase
    end

`ifdef SSEG_LZB_EN
    // Blank digit k when it and every more significant nibble are zero
    always_comb begin
        w_blank_next = 1'b0;
        case (r_index)
            2'd1: w_blank_next = (w_disp_next[15:4]  == 12'd0);
            2'd2: w_blank_next = (w_disp_next[15:8]  == 8'd0);
            2'd3: w_blank_next = (w_disp_next[15:12] == 4'd0);
            default: w_blank_next = 1'b0;
        endcase
    end
`else
    assign w_blank_next = 1'b0;
`endif

    // Output registers: anode, nibble and blank switch on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an    <= c_an_dig0;
            r_digit <= 4'd0;
            r_blank <= 1'b0;
        end else begin
            r_an    <= w_an_next;
            r_digit <= w_disp_next[{r_index, 2'b00} +: 4];
            r_blank <= w_blank_next;
        end
    end

    assign an    = r_an;
    assign digit = r_digit;
    assign blank = r_blank;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
// ============================================================================
//  Module      : tb_sseg_scan_driver
//  Description : Self-checking bench for sseg_scan_driver. Expected outputs come
//                from a decimal reference model of the displayed value and the
//                elapsed cycle count since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_driver;

    localparam int DIV   = 4;
    localparam int VAL_W = 14;
`ifdef SSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [VAL_W-1:0] value = '0;
    logic             busy;
    logic             done;
    logic [3:0]       digit;
    logic             blank;
    logic [3:0]       an;

    sseg_scan_driver #(
        .REFRESH_DIV (DIV),
        .VAL_W       (VAL_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .digit (digit),
        .blank (blank),
        .an    (an)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since the last reset edge
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int exp_disp   = 0;
    int pend       = 0;
    int load_cyc   = 0;
    int commit_cyc = 0;
    bit active     = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    endtask

    task automatic check_all();
        int         k;
        int         p;
        logic [3:0] ea;
        logic [3:0] ed;
        logic       eb;
        k  = (cyc == 0) ? 0 : ((cyc - 1) / DIV) % 4;
        p  = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        ea = ~(4'b0001 << k);
        ed = 4'((exp_disp / p) % 10);
        eb = LZB && (k > 0) && (exp_disp < p);
        chk("an",    16'(an),    16'(ea));
        chk("digit", 16'(digit), 16'(ed));
        chk("blank", 16'(blank), 16'(eb));
        chk("busy",  16'(busy),  16'(active && cyc > load_cyc && cyc <= commit_cyc));
        chk("done",  16'(done),  16'(active && cyc == commit_cyc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (active && cyc == commit_cyc + 1) begin
            exp_disp = pend;
            active   = 1'b0;
        end
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input int v);
        value = VAL_W'(v);
        load  = 1'b1;
        if (!active) begin
            active     = 1'b1;
            load_cyc   = cyc;
            commit_cyc = cyc + VAL_W + 1;
            pend       = (v > 9999) ? 9999 : v;
        end
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        active   = 1'b0;
        exp_disp = 0;
        check_all();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (active && guard < 50) begin
            tick();
            guard++;
        end
        chk("idle_timeout", 16'(active), 16'(0));
    endtask

    initial begin
        // Reset state and free-running scan over several wraps
        do_reset();
        ticks(20);

        // Basic conversion and full scan of 1234
        do_load(1234);
        wait_idle();
        ticks(18);

        // Saturation
        do_load(12000);
        wait_idle();
        ticks(18);

        // Small value exercising leading-zero handling
        do_load(7);
        wait_idle();
        ticks(18);

        // Zero shows a single digit when blanking is enabled
        do_load(0);
        wait_idle();
        ticks(18);

        // Load during conversion is ignored
        do_load(1234);
        wait_idle();
        ticks(5);
        do_load(56);
        ticks(4);
        do_load(4321);
        wait_idle();
        ticks(18);

        // Reset mid-conversion aborts it, then a fresh conversion works
        do_load(4321);
        ticks(7);
        do_reset();
        ticks(18);
        do_load(4321);
        wait_idle();
        ticks(10);

        // Back-to-back: load in the cycle right after commit
        do_load(9876);
        wait_idle();
        do_load(305);
        wait_idle();
        ticks(18);

        // Randomized values with random extra load pulses
        for (int i = 0; i < 12; i++) begin
            do_load(int'($urandom_range(0, 16383)));
            if ($urandom_range(0, 1) == 1) begin
                ticks(int'($urandom_range(0, 8)));
                do_load(int'($urandom_range(0, 16383)));
            end
            wait_idle();
            ticks(int'($urandom_range(0, 17)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
